sirv_gnrl_sfifo: RTL

- Synchronous valid/ready FIFO built from load-enabled, zero-reset registers.
- Sits between a producer pipeline stage and the general load-enable flop arrays.
  - Decodes push/pop handshakes into per-entry load enables.
  - Decodes the corresponding next-data values for those entries.
- Used to buffer and decouple pipeline stages.
- Both ready and valid outputs are registered-state functions; there is no combinational path from the input handshake to the output handshake.

---
 rtl/sirv_gnrl_sfifo_if.sv | 28 ++
 rtl/sirv_gnrl_sfifo.sv | 79 +++++++
 2 files changed

// File: rtl/sirv_gnrl_sfifo_if.sv
// Valid/ready handshake bundle for sirv_gnrl_sfifo: producer side (i_*),
// consumer side (o_*) and occupancy status.
interface sirv_gnrl_sfifo_if #(
  parameter int DP = 4,
  parameter int DW = 32
);
  localparam int CW = $clog2(DP + 1);

  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat, cnt, full, empty
  );

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat, cnt, full, empty
  );
endinterface

// File: rtl/sirv_gnrl_sfifo.sv
// Synchronous valid/ready FIFO over DP load-enabled, zero-reset entries.
// Handshake outputs depend only on registered occupancy.
module sirv_gnrl_sfifo #(
  parameter int DP = 4,
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst_n,
  sirv_gnrl_sfifo_if.slave bus
);
  localparam int CW = $clog2(DP + 1);
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;

  logic [DW-1:0] r_mem [DP];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [DP-1:0] w_wen;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_full  = (r_cnt == CW'(DP));
  assign w_empty = (r_cnt == '0);
  assign w_push  = bus.i_vld & ~w_full;
  assign w_pop   = bus.o_rdy & ~w_empty;

  always_comb begin
    w_wen = '0;
    for (int unsigned k = 0; k < DP; k++) begin
      w_wen[k] = w_push && (r_wptr == PW'(k));
    end
  end

  // Explicit wrap so non power-of-two depths never index past DP-1.
  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    if (w_push) w_wptr_nxt = (r_wptr == PW'(DP - 1)) ? '0 : r_wptr + 1'b1;
    if (w_pop)  w_rptr_nxt = (r_rptr == PW'(DP - 1)) ? '0 : r_rptr + 1'b1;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int unsigned k = 0; k < DP; k++) r_mem[k] <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_cnt  <= w_cnt_nxt;
      for (int unsigned k = 0; k < DP; k++) begin
        if (w_wen[k]) r_mem[k] <= bus.i_dat;
      end
    end
  end

  assign bus.i_rdy = ~w_full;
  assign bus.o_vld = ~w_empty;
  assign bus.o_dat = r_mem[r_rptr];
  assign bus.cnt   = r_cnt;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
endmodule
